pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage integer pipeline.
- Replaces the standalone forwarding unit and adds load-use stall, branch/jump flush generation and multi-cycle EX-op freeze (MULT/DIV).
- Sits beside the pipeline registers; drives PC/IF-ID write enables, bubble/flush strobes and the EX operand forward selects.

Parameters:
- REG_W, 5, register index width.
- MC_LAT, 4, cycles a multi-cycle EX op occupies EX (>=2).
- BRANCH_STAGE, 3, stage resolving branches: 2=EX, 3=MEM.
- CNT_W, 16, stall-cycle performance counter width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  REG_W  source regs of instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs/rt
- id_jump  in  1  ID holds J/JAL
- ex_rs, ex_rt  in  REG_W  source regs of instruction in EX
- ex_dst  in  REG_W  destination of EX instruction
- ex_regwrite, ex_memread  in  1  EX control bits
- mc_start  in  1  EX instruction is a multi-cycle op (first EX cycle)
- mem_dst  in  REG_W; mem_regwrite  in  1
- wb_dst  in  REG_W; wb_regwrite  in  1
- branch_taken  in  1  taken branch resolved in BRANCH_STAGE
- pc_write, if_id_write  out  1  enables (1 = advance)
- id_ex_bubble  out  1  load zeros into ID/EX control
- ex_mem_bubble  out  1  load zeros into EX/MEM control
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  squash strobes
- ex_hold  out  1  freeze ID/EX register contents
- fwd_a, fwd_b  out  2  00 regfile, 01 WB data, 10 EX/MEM result
- mc_done  out  1  one-cycle pulse on last multi-cycle EX cycle
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (async, rst high): state IDLE, mc counter 0, stall_cycles 0.
  - Outputs: pc_write=1, if_id_write=1, all bubble/flush/hold/mc_done=0, fwd=00.
- Forwarding (combinational, every cycle):
  - fwd_a=10 if mem_regwrite && mem_dst!=0 && mem_dst==ex_rs; else 01 if wb_regwrite && wb_dst!=0 && wb_dst==ex_rs; else 00.
  - fwd_b identical on ex_rt. MEM beats WB. Register 0 is never forwarded.
- Load-use: ex_memread && ex_regwrite && ex_dst!=0 && ((id_uses_rs && id_rs==ex_dst) || (id_uses_rt && id_rt==ex_dst)).
  - Effect: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle.
- FSM states: IDLE, MC_BUSY.
  - IDLE + mc_start (no branch_taken) -> MC_BUSY, counter <= MC_LAT-2.
  - Every MC_BUSY cycle and the mc_start cycle: pc_write=0, if_id_write=0, ex_hold=1, ex_mem_bubble=1.
  - MC_BUSY: counter decrements. When counter==0: mc_done=1, ex_hold=0, ex_mem_bubble=0 (result passes to EX/MEM), then -> IDLE.
  - Total EX occupancy is exactly MC_LAT cycles.
- Jump: id_jump && no stall && IDLE -> if_id_flush=1 (kills delay-slot fetch).
  - Suppressed while stalled; the jump stays in ID and flushes on the cycle it advances.
- branch_taken (highest priority, same cycle):
  - Always: if_id_flush=1, id_ex_flush=1.
  - BRANCH_STAGE=3 also asserts ex_mem_flush=1.
  - Overrides load-use stall and jump (pc_write=1, if_id_write=1).
  - In MC_BUSY or with mc_start: op is wrong-path. FSM -> IDLE, counter cleared, no mc_done, ex_hold=0.
- Priority: rst > branch_taken > multi-cycle freeze > load-use > jump.
- Load-use during MC_BUSY: freeze dominates. The stall re-evaluates after the freeze ends, no double count.
- stall_cycles: +1 each cycle pc_write==0. Holds at 2^CNT_W-1.
- rst mid-MC_BUSY: immediate return to IDLE; outputs at reset values.

Decomposition:
- Shared package pipe_pkg:
  - fwd select encodings (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - FSM state typedef.
  - BRANCH_STAGE constants (BR_EX=2, BR_MEM=3).
- One sub-module: pipe_fwd_sel, the combinational per-operand priority compare, instantiated twice (a and b).
- FSM, counters and stall/flush logic live in the top.

Test Plan:
- Forwarding: ex_rs=19, mem_dst=19/mem_regwrite=1, wb_dst=19/wb_regwrite=1 -> fwd_a=10; drop mem_regwrite -> 01; set all dst=0 -> 00.
- Load-use: ex_memread=1, ex_dst=20, id_rs=20, id_uses_rs=1 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (EX now non-load) pc_write=1; stall_cycles=1.
- Multi-cycle (MC_LAT=4): mc_start pulse -> ex_hold=1 for 3 cycles, mc_done on 4th, pc_write=0 for 4 cycles, stall_cycles +4.
- Branch kills multi-cycle: branch_taken in 2nd MC_BUSY cycle -> flushes asserted that cycle, state IDLE next cycle, mc_done never pulses.
- Branch overrides load-use and jump, BRANCH_STAGE=2 vs 3: ex_mem_flush=0 vs 1; pc_write=1 in both.
- Async reset: assert rst mid-MC_BUSY between clock edges -> outputs return to reset values immediately; stall_cycles=0; saturation check with CNT_W=2 holds at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage pipeline hazard/forwarding control.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int BR_EX  = 2;
    localparam int BR_MEM = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forward select: EX/MEM result beats WB data, r0 never forwarded.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_regwrite,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && mem_dst != '0 && mem_dst == src)
            sel = FWD_MEM;
        else if (wb_regwrite && wb_dst != '0 && wb_dst == src)
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, multi-cycle EX freeze,
// jump/branch flush generation and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int MC_LAT       = 4,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             mc_start,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             ex_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MC_CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    mc_state_t        state;
    logic [MC_CW-1:0] mc_cnt;
    logic [1:0]       sel_a, sel_b;
    logic             load_use, freeze, mc_last;

    pipe_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src(ex_rs), .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
        .wb_dst(wb_dst), .wb_regwrite(wb_regwrite), .sel(sel_a)
    );
    pipe_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src(ex_rt), .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
        .wb_dst(wb_dst), .wb_regwrite(wb_regwrite), .sel(sel_b)
    );

    // Reset forces every output to its idle value without waiting for a clock.
    assign fwd_a = rst ? FWD_RF : sel_a;
    assign fwd_b = rst ? FWD_RF : sel_b;

    always_comb begin
        load_use = ex_memread && ex_regwrite && ex_dst != '0 &&
                   ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
        freeze   = (state == MC_BUSY) || mc_start;
        mc_last  = (state == MC_BUSY) && (mc_cnt == '0);

        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        ex_hold       = 1'b0;
        mc_done       = 1'b0;

        if (rst) begin
            // defaults already hold the reset values
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = (BRANCH_STAGE == BR_MEM);
        end else if (freeze) begin
            // On the last cycle the result is released into EX/MEM.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_hold       = !mc_last;
            ex_mem_bubble = !mc_last;
            mc_done       = mc_last;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mc_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            if (!pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;

            if (branch_taken) begin
                state  <= IDLE;
                mc_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (mc_start) begin
                        state  <= MC_BUSY;
                        mc_cnt <= MC_CW'(MC_LAT - 2);
                    end
                    MC_BUSY: begin
                        if (mc_cnt == '0) state  <= IDLE;
                        else              mc_cnt <= mc_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
